// File: rtl/mux_4_1_arb_v_if.sv
// rtl/mux_4_1_arb_v_if.sv - four source channels and one sink channel of the 4:1 arbitrating mux
interface mux_4_1_arb_v_if #(
    parameter int P_WIDTH = 8
);
    logic [P_WIDTH-1:0] i_a_data;
    logic               i_a_valid;
    logic               o_a_ready;
    logic [P_WIDTH-1:0] i_b_data;
    logic               i_b_valid;
    logic               o_b_ready;
    logic [P_WIDTH-1:0] i_c_data;
    logic               i_c_valid;
    logic               o_c_ready;
    logic [P_WIDTH-1:0] i_d_data;
    logic               i_d_valid;
    logic               o_d_ready;
    logic [P_WIDTH-1:0] o_data;
    logic [1:0]         o_src;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output i_a_data, i_a_valid, i_b_data, i_b_valid,
        output i_c_data, i_c_valid, i_d_data, i_d_valid, i_ready,
        input  o_a_ready, o_b_ready, o_c_ready, o_d_ready,
        input  o_data, o_src, o_valid
    );

    modport slave (
        input  i_a_data, i_a_valid, i_b_data, i_b_valid,
        input  i_c_data, i_c_valid, i_d_data, i_d_valid, i_ready,
        output o_a_ready, o_b_ready, o_c_ready, o_d_ready,
        output o_data, o_src, o_valid
    );
endinterface

// File: rtl/mux_4_1_arb_v.sv
// rtl/mux_4_1_arb_v.sv - 4:1 arbitrating mux with valid/ready handshakes and a registered output stage
module mux_4_1_arb_v #(
    parameter int P_WIDTH = 8,
    parameter bit P_RR    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mux_4_1_arb_v_if.slave       bus
);
    logic [P_WIDTH-1:0] data_q, data_d;
    logic [1:0]         src_q, src_d;
    logic               valid_q, valid_d;
    logic [1:0]         last_q, last_d;

    logic [3:0]         req;
    logic [P_WIDTH-1:0] data_arr [4];
    logic               ld;
    logic [3:0]         grant;
    logic [1:0]         grant_idx;
    logic               grant_any;
    logic [1:0]         idx;

    assign req         = {bus.i_d_valid, bus.i_c_valid, bus.i_b_valid, bus.i_a_valid};
    assign data_arr[0] = bus.i_a_data;
    assign data_arr[1] = bus.i_b_data;
    assign data_arr[2] = bus.i_c_data;
    assign data_arr[3] = bus.i_d_data;

    // The register can take a beat when empty or when its current beat leaves this cycle.
    assign ld = ~valid_q | bus.i_ready;

    // First requester wins, scanning from the slot after the last winner (RR) or from a (fixed).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = P_RR ? (last_q + 2'(i + 1)) : 2'(i);
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    end

    // Gating with reset keeps every source handshake blocked while reset is held.
    assign bus.o_a_ready = ld & grant[0] & i_rst_n;
    assign bus.o_b_ready = ld & grant[1] & i_rst_n;
    assign bus.o_c_ready = ld & grant[2] & i_rst_n;
    assign bus.o_d_ready = ld & grant[3] & i_rst_n;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (ld) begin
            valid_d = grant_any;
            if (grant_any) begin
                data_d = data_arr[grant_idx];
                src_d  = grant_idx;
                if (P_RR) begin
                    last_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_src   = src_q;
    assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_mux_4_1_arb_v.sv
// tb/tb_mux_4_1_arb_v.sv - scoreboard bench for mux_4_1_arb_v in round-robin and fixed-priority modes
module tb_mux_4_1_arb_v;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [9:0] rq [$];
    logic [9:0] fq [$];

    mux_4_1_arb_v_if #(.P_WIDTH(8)) rb ();
    mux_4_1_arb_v_if #(.P_WIDTH(8)) fb ();

    mux_4_1_arb_v #(.P_WIDTH(8), .P_RR(1'b1)) dut_rr (.i_clk(clk), .i_rst_n(rst_n), .bus(rb));
    mux_4_1_arb_v #(.P_WIDTH(8), .P_RR(1'b0)) dut_fp (.i_clk(clk), .i_rst_n(rst_n), .bus(fb));

    logic [3:0] rb_rdy;
    logic [3:0] fb_rdy;
    assign rb_rdy = {rb.o_d_ready, rb.o_c_ready, rb.o_b_ready, rb.o_a_ready};
    assign fb_rdy = {fb.o_d_ready, fb.o_c_ready, fb.o_b_ready, fb.o_a_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rb_drive(input logic [3:0] v, input logic [7:0] da, input logic [7:0] db,
                            input logic [7:0] dc, input logic [7:0] dd);
        rb.i_a_valid = v[0]; rb.i_a_data = da;
        rb.i_b_valid = v[1]; rb.i_b_data = db;
        rb.i_c_valid = v[2]; rb.i_c_data = dc;
        rb.i_d_valid = v[3]; rb.i_d_data = dd;
    endtask

    task automatic fb_drive(input logic [3:0] v, input logic [7:0] da, input logic [7:0] dd);
        fb.i_a_valid = v[0]; fb.i_a_data = da;
        fb.i_b_valid = v[1]; fb.i_b_data = 8'h00;
        fb.i_c_valid = v[2]; fb.i_c_data = 8'h00;
        fb.i_d_valid = v[3]; fb.i_d_data = dd;
    endtask

    // Scoreboard monitors: each beat the sink consumes is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n && rb.o_valid && rb.i_ready) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL rr_unexpected_beat: got src %0d data 0x%0h, expected none", rb.o_src, rb.o_data);
            end else begin
                logic [9:0] e;
                e = rq.pop_front();
                if ({rb.o_src, rb.o_data} !== e) begin
                    miscompares++;
                    $display("FAIL rr_beat: got src %0d data 0x%0h, expected src %0d data 0x%0h",
                             rb.o_src, rb.o_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fb.o_valid && fb.i_ready) begin
            vectors++;
            if (fq.size() == 0) begin
                miscompares++;
                $display("FAIL fp_unexpected_beat: got src %0d data 0x%0h, expected none", fb.o_src, fb.o_data);
            end else begin
                logic [9:0] e;
                e = fq.pop_front();
                if ({fb.o_src, fb.o_data} !== e) begin
                    miscompares++;
                    $display("FAIL fp_beat: got src %0d data 0x%0h, expected src %0d data 0x%0h",
                             fb.o_src, fb.o_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        rb.i_ready  = 1'b0;
        fb.i_ready  = 1'b0;
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        fb_drive(4'b0000, 8'h00, 8'h00);
        #1;
        chk("reset_valid", rb.o_valid, 0);
        chk("reset_ready", rb_rdy, 4'b0000);
        repeat (2) cyc();
        rst_n = 1'b1;

        // 1: reset mid-stream, then a has first priority
        rb_drive(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
        @(negedge clk); chk("t1_c_ready", rb_rdy, 4'b0100);
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("t1_full_data", {rb.o_valid, rb.o_src, rb.o_data}, {1'b1, 2'd2, 8'h5A});
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_valid", rb.o_valid, 0);
        chk("t1_async_data", rb.o_data, 0);
        chk("t1_async_src", rb.o_src, 0);
        rb_drive(4'b1001, 8'h11, 8'h00, 8'h00, 8'h44);
        #1;
        chk("t1_reset_ready", rb_rdy, 4'b0000);
        chk("t1_fp_reset_valid", fb.o_valid, 0);
        cyc();
        rst_n = 1'b1;
        rb.i_ready = 1'b1;
        rq.push_back({2'd0, 8'h11});
        @(negedge clk); chk("t1_a_first", rb_rdy, 4'b0001);
        cyc();
        rb_drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h44);
        rq.push_back({2'd3, 8'h44});
        @(negedge clk); chk("t1_d_next", rb_rdy, 4'b1000);
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();

        // 2: round-robin rotation a, b, c, d, a
        rb_drive(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] s;
            s = 2'(k);
            rq.push_back({s, 8'(8'h10 * (s + 1))});
            @(negedge clk); chk("t2_rr_ready", rb_rdy, 4'b0001 << s);
            if (k > 0) chk("t2_valid_steady", rb.o_valid, 1);
            cyc();
        end
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();

        // 3: back-pressure holds b; c follows when released (last = 1)
        rb.i_ready = 1'b0;
        rb_drive(4'b0010, 8'h00, 8'h22, 8'h00, 8'h00);
        rq.push_back({2'd1, 8'h22});
        cyc();
        rb_drive(4'b0101, 8'hA1, 8'h00, 8'hC3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold", {rb.o_valid, rb.o_src, rb.o_data}, {1'b1, 2'd1, 8'h22});
            chk("t3_no_ready", rb_rdy, 4'b0000);
            cyc();
        end
        rb.i_ready = 1'b1;
        rq.push_back({2'd2, 8'hC3});
        @(negedge clk); chk("t3_c_ready", rb_rdy, 4'b0100);
        cyc();
        rb_drive(4'b0001, 8'hA1, 8'h00, 8'h00, 8'h00);
        rq.push_back({2'd0, 8'hA1});
        @(negedge clk); chk("t3_a_ready", rb_rdy, 4'b0001);
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();

        // 5: single beat from d drains to empty, then a granted immediately
        rb_drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h99);
        rq.push_back({2'd3, 8'h99});
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk); chk("t5_one_beat", {rb.o_valid, rb.o_src}, {1'b1, 2'd3});
        cyc();
        rb_drive(4'b0001, 8'h5E, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("t5_empty", rb.o_valid, 0);
        chk("t5_a_ready", rb_rdy, 4'b0001);
        rq.push_back({2'd0, 8'h5E});
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();

        // 6: sparse wrap from last = 2, only b requesting; then c beats a (last = 1)
        rb_drive(4'b0100, 8'h00, 8'h00, 8'h33, 8'h00);
        rq.push_back({2'd2, 8'h33});
        cyc();
        rb_drive(4'b0010, 8'h00, 8'hBB, 8'h00, 8'h00);
        rq.push_back({2'd1, 8'hBB});
        @(negedge clk); chk("t6_b_ready", rb_rdy, 4'b0010);
        cyc();
        rb_drive(4'b0101, 8'h0A, 8'h00, 8'h0C, 8'h00);
        rq.push_back({2'd2, 8'h0C});
        @(negedge clk); chk("t6_c_after_b", rb_rdy, 4'b0100);
        cyc();
        rb_drive(4'b0001, 8'h0A, 8'h00, 8'h00, 8'h00);
        rq.push_back({2'd0, 8'h0A});
        cyc();
        rb_drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) cyc();

        // 4: fixed priority on the second instance
        fb.i_ready = 1'b1;
        fb_drive(4'b1001, 8'hA4, 8'h44);
        for (int k = 0; k < 4; k++) begin
            fq.push_back({2'd0, 8'hA4});
            @(negedge clk); chk("t4_a_only", fb_rdy, 4'b0001);
            cyc();
        end
        fb_drive(4'b1000, 8'h00, 8'h44);
        fq.push_back({2'd3, 8'h44});
        @(negedge clk); chk("t4_d_after", fb_rdy, 4'b1000);
        cyc();
        fb_drive(4'b0000, 8'h00, 8'h00);
        repeat (2) cyc();

        chk("rr_queue_empty", rq.size(), 0);
        chk("fp_queue_empty", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
